// File: rtl/id_scoreboard.sv
// ID-stage register-hazard interlock: integer/float busy scoreboards for in-flight
// multi-cycle ops, plus load-use and branch-in-ID hazard detection driving one stall.
module id_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rs3,
    input  logic [2:0]  id_rs_used,
    input  logic [2:0]  id_rs_float,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_float,
    input  logic        id_rd_we,
    input  logic        id_multicycle,
    input  logic        id_is_branch,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_float,
    input  logic        ex_we,
    input  logic        ex_memr,
    input  logic [4:0]  mem_rd,
    input  logic        mem_rd_float,
    input  logic        mem_we,
    input  logic        mem_memr,
    input  logic        mc_wb_valid,
    input  logic [4:0]  mc_wb_rd,
    input  logic        mc_wb_float,
    input  logic        flush,
    output logic        stall_id,
    output logic [31:0] busy_int,
    output logic [31:0] busy_fp,
    output logic [3:0]  outstanding,
    output logic        err_spurious
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    logic [31:0] busy_int_q, busy_int_d;
    logic [31:0] busy_fp_q, busy_fp_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic        err_q, err_d;

    // Integer x0 is hard-wired zero and never a real dependency; f0 is a real register.
    function automatic logic reg_match(input logic [4:0] a, input logic fa,
                                       input logic [4:0] b, input logic fb);
        return (a == b) && (fa == fb) && !(!fa && (a == 5'd0));
    endfunction

    logic rs1_busy, rs2_busy, rs3_busy, rd_busy, wb_busy, rd_is_x0;
    logic ex_hit1, ex_hit2, ex_hit3, mem_hit1, mem_hit2;
    logic raw_sb, waw_sb, load_use, br_ex, br_mem, structural;
    logic issue, track, retire, spurious;

    always_comb begin
        rs1_busy = id_rs_used[2] && (id_rs_float[2] ? busy_fp_q[id_rs1] : busy_int_q[id_rs1]);
        rs2_busy = id_rs_used[1] && (id_rs_float[1] ? busy_fp_q[id_rs2] : busy_int_q[id_rs2]);
        rs3_busy = id_rs_used[0] && (id_rs_float[0] ? busy_fp_q[id_rs3] : busy_int_q[id_rs3]);
        rd_busy  = id_rd_float ? busy_fp_q[id_rd] : busy_int_q[id_rd];
        rd_is_x0 = !id_rd_float && (id_rd == 5'd0);

        ex_hit1  = id_rs_used[2] && reg_match(ex_rd, ex_rd_float, id_rs1, id_rs_float[2]);
        ex_hit2  = id_rs_used[1] && reg_match(ex_rd, ex_rd_float, id_rs2, id_rs_float[1]);
        ex_hit3  = id_rs_used[0] && reg_match(ex_rd, ex_rd_float, id_rs3, id_rs_float[0]);
        mem_hit1 = id_rs_used[2] && reg_match(mem_rd, mem_rd_float, id_rs1, id_rs_float[2]);
        mem_hit2 = id_rs_used[1] && reg_match(mem_rd, mem_rd_float, id_rs2, id_rs_float[1]);

        raw_sb     = rs1_busy || rs2_busy || rs3_busy;
        waw_sb     = id_rd_we && rd_busy && !rd_is_x0;
        load_use   = ex_memr && ex_we && (ex_hit1 || ex_hit2 || ex_hit3);
        br_ex      = id_is_branch && ex_we && (ex_hit1 || ex_hit2);
        br_mem     = id_is_branch && mem_memr && mem_we && (mem_hit1 || mem_hit2);
        // Uses the registered count so a same-cycle retire cannot release the stall.
        structural = id_multicycle && (outstanding_q == MaxOut);

        stall_id = id_valid && (raw_sb || waw_sb || load_use || br_ex || br_mem || structural);
        issue    = id_valid && !stall_id && !flush;
        track    = issue && id_multicycle && id_rd_we && !rd_is_x0;

        wb_busy  = mc_wb_float ? busy_fp_q[mc_wb_rd] : busy_int_q[mc_wb_rd];
        retire   = mc_wb_valid && wb_busy;
        spurious = mc_wb_valid && !wb_busy;
    end

    always_comb begin
        busy_int_d    = busy_int_q;
        busy_fp_d     = busy_fp_q;
        outstanding_d = outstanding_q;
        err_d         = err_q || spurious;

        if (retire) begin
            if (mc_wb_float) busy_fp_d[mc_wb_rd] = 1'b0;
            else             busy_int_d[mc_wb_rd] = 1'b0;
        end
        // Track and retire never hit the same register: WAW stalls such an issue.
        if (track) begin
            if (id_rd_float) busy_fp_d[id_rd] = 1'b1;
            else             busy_int_d[id_rd] = 1'b1;
        end

        unique case ({track, retire})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_int_q    <= '0;
            busy_fp_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_int_q    <= busy_int_d;
            busy_fp_q     <= busy_fp_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign busy_int     = busy_int_q;
    assign busy_fp      = busy_fp_q;
    assign outstanding  = outstanding_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops one per cycle and compares against the DUT.
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rs3;
    logic [2:0]  id_rs_used, id_rs_float;
    logic [4:0]  id_rd;
    logic        id_rd_float, id_rd_we, id_multicycle, id_is_branch;
    logic [4:0]  ex_rd;
    logic        ex_rd_float, ex_we, ex_memr;
    logic [4:0]  mem_rd;
    logic        mem_rd_float, mem_we, mem_memr;
    logic        mc_wb_valid;
    logic [4:0]  mc_wb_rd;
    logic        mc_wb_float;
    logic        flush;
    logic        stall_id;
    logic [31:0] busy_int, busy_fp;
    logic [3:0]  outstanding;
    logic        err_spurious;

    id_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_rs_used(id_rs_used), .id_rs_float(id_rs_float),
        .id_rd(id_rd), .id_rd_float(id_rd_float), .id_rd_we(id_rd_we),
        .id_multicycle(id_multicycle), .id_is_branch(id_is_branch),
        .ex_rd(ex_rd), .ex_rd_float(ex_rd_float), .ex_we(ex_we), .ex_memr(ex_memr),
        .mem_rd(mem_rd), .mem_rd_float(mem_rd_float), .mem_we(mem_we), .mem_memr(mem_memr),
        .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd), .mc_wb_float(mc_wb_float),
        .flush(flush), .stall_id(stall_id), .busy_int(busy_int), .busy_fp(busy_fp),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] bi;
        logic [31:0] bf;
        logic [3:0]  outs;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
        end
    endtask

    // Monitor: one expectation per stimulus cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk(x.name, "stall_id", 32'(stall_id), 32'(x.stall));
            chk(x.name, "busy_int", busy_int, x.bi);
            chk(x.name, "busy_fp", busy_fp, x.bf);
            chk(x.name, "outstanding", 32'(outstanding), 32'(x.outs));
            chk(x.name, "err_spurious", 32'(err_spurious), 32'(x.err));
        end
    end

    task automatic expect_cyc(input string name, input logic st, input logic [31:0] bi,
                              input logic [31:0] bf, input logic [3:0] o, input logic e);
        exp_t x;
        x.name = name; x.stall = st; x.bi = bi; x.bf = bf; x.outs = o; x.err = e;
        q.push_back(x);
    endtask

    // Advance one cycle and clear all stage inputs.
    task automatic nxt();
        @(posedge clk);
        #1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_rs_used = 0; id_rs_float = 0;
        id_rd = 0; id_rd_float = 0; id_rd_we = 0; id_multicycle = 0; id_is_branch = 0;
        ex_rd = 0; ex_rd_float = 0; ex_we = 0; ex_memr = 0;
        mem_rd = 0; mem_rd_float = 0; mem_we = 0; mem_memr = 0;
        mc_wb_valid = 0; mc_wb_rd = 0; mc_wb_float = 0; flush = 0;
    endtask

    task automatic id_ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                          input logic [2:0] used, input logic [2:0] fl, input logic [4:0] rd,
                          input logic rdf, input logic we, input logic mc, input logic br);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rs3 = rs3; id_rs_used = used;
        id_rs_float = fl; id_rd = rd; id_rd_float = rdf; id_rd_we = we;
        id_multicycle = mc; id_is_branch = br;
    endtask

    task automatic wb(input logic [4:0] rd, input logic f);
        mc_wb_valid = 1; mc_wb_rd = rd; mc_wb_float = f;
    endtask

    initial begin
        // Reset held: consumer of f3 must not stall
        nxt(); id_ins(3, 0, 0, 3'b100, 3'b100, 5, 1, 1, 0, 0);
        expect_cyc("reset", 0, 0, 0, 0, 0);

        // fdiv f3 then fadd f5 <- f3,f4
        nxt(); rst_n = 1; id_ins(1, 2, 0, 3'b110, 3'b110, 3, 1, 1, 1, 0);
        expect_cyc("fdiv_issue", 0, 0, 0, 0, 0);
        nxt(); id_ins(3, 4, 0, 3'b110, 3'b110, 5, 1, 1, 0, 0);
        expect_cyc("raw_wait1", 1, 0, 32'h8, 1, 0);
        nxt(); id_ins(3, 4, 0, 3'b110, 3'b110, 5, 1, 1, 0, 0);
        expect_cyc("raw_wait2", 1, 0, 32'h8, 1, 0);
        nxt(); id_ins(3, 4, 0, 3'b110, 3'b110, 5, 1, 1, 0, 0); wb(3, 1);
        expect_cyc("raw_wb_cycle", 1, 0, 32'h8, 1, 0);
        nxt(); id_ins(3, 4, 0, 3'b110, 3'b110, 5, 1, 1, 0, 0);
        expect_cyc("raw_release", 0, 0, 0, 0, 0);

        // Hazards present but id_valid low
        nxt(); ex_memr = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_rs_used = 3'b100;
        expect_cyc("no_valid", 0, 0, 0, 0, 0);

        // Load-use on x5, then forwarded from MEM
        nxt(); ex_memr = 1; ex_we = 1; ex_rd = 5; id_ins(5, 1, 0, 3'b110, 0, 6, 0, 1, 0, 0);
        expect_cyc("load_use", 1, 0, 0, 0, 0);
        nxt(); mem_memr = 1; mem_we = 1; mem_rd = 5; id_ins(5, 1, 0, 3'b110, 0, 6, 0, 1, 0, 0);
        expect_cyc("load_use_fwd", 0, 0, 0, 0, 0);
        nxt(); ex_memr = 1; ex_we = 1; ex_rd = 0; id_ins(0, 1, 0, 3'b110, 0, 6, 0, 1, 0, 0);
        expect_cyc("load_x0", 0, 0, 0, 0, 0);
        nxt(); ex_memr = 1; ex_we = 1; ex_rd = 0; ex_rd_float = 1;
        id_ins(0, 1, 0, 3'b110, 3'b100, 6, 1, 1, 0, 0);
        expect_cyc("load_f0", 1, 0, 0, 0, 0);

        // beq x7 after addi x7: one cycle
        nxt(); ex_we = 1; ex_rd = 7; id_ins(7, 8, 0, 3'b110, 0, 0, 0, 0, 0, 1);
        expect_cyc("br_alu_ex", 1, 0, 0, 0, 0);
        nxt(); mem_we = 1; mem_rd = 7; id_ins(7, 8, 0, 3'b110, 0, 0, 0, 0, 0, 1);
        expect_cyc("br_alu_mem", 0, 0, 0, 0, 0);
        // beq x7 after lw x7: two cycles
        nxt(); ex_we = 1; ex_memr = 1; ex_rd = 7; id_ins(8, 7, 0, 3'b110, 0, 0, 0, 0, 0, 1);
        expect_cyc("br_ld_ex", 1, 0, 0, 0, 0);
        nxt(); mem_we = 1; mem_memr = 1; mem_rd = 7; id_ins(8, 7, 0, 3'b110, 0, 0, 0, 0, 0, 1);
        expect_cyc("br_ld_mem", 1, 0, 0, 0, 0);
        nxt(); id_ins(8, 7, 0, 3'b110, 0, 0, 0, 0, 0, 1);
        expect_cyc("br_ld_done", 0, 0, 0, 0, 0);

        // Fill to MAX_OUTSTANDING with f1..f4, then a fifth op to f6
        nxt(); id_ins(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        expect_cyc("fill_f1", 0, 0, 0, 0, 0);
        nxt(); id_ins(0, 0, 0, 0, 0, 2, 1, 1, 1, 0);
        expect_cyc("fill_f2", 0, 0, 32'h2, 1, 0);
        nxt(); id_ins(0, 0, 0, 0, 0, 3, 1, 1, 1, 0);
        expect_cyc("fill_f3", 0, 0, 32'h6, 2, 0);
        nxt(); id_ins(0, 0, 0, 0, 0, 4, 1, 1, 1, 0);
        expect_cyc("fill_f4", 0, 0, 32'hE, 3, 0);
        nxt(); id_ins(0, 0, 0, 0, 0, 6, 1, 1, 1, 0);
        expect_cyc("struct_full", 1, 0, 32'h1E, 4, 0);
        nxt(); id_ins(0, 0, 0, 0, 0, 6, 1, 1, 1, 0); wb(2, 1);
        expect_cyc("struct_wb_same", 1, 0, 32'h1E, 4, 0);
        nxt(); id_ins(0, 0, 0, 0, 0, 6, 1, 1, 1, 0);
        expect_cyc("struct_release", 0, 0, 32'h1A, 3, 0);
        nxt();
        expect_cyc("struct_refill", 0, 0, 32'h5A, 4, 0);

        // Spurious writeback to f9
        nxt(); wb(9, 1);
        expect_cyc("spur_cycle", 0, 0, 32'h5A, 4, 0);
        nxt(); wb(3, 1);
        expect_cyc("spur_sticky", 0, 0, 32'h5A, 4, 1);
        // Issue f2 while retiring f1
        nxt(); id_ins(0, 0, 0, 0, 0, 2, 1, 1, 1, 0); wb(1, 1);
        expect_cyc("track_retire", 0, 0, 32'h52, 3, 1);
        nxt(); id_ins(0, 0, 6, 3'b001, 3'b001, 9, 1, 1, 0, 0);
        expect_cyc("raw_rs3", 1, 0, 32'h54, 3, 1);
        nxt(); id_ins(0, 0, 6, 3'b000, 3'b001, 9, 1, 1, 0, 0);
        expect_cyc("rs3_unused", 0, 0, 32'h54, 3, 1);
        nxt(); id_ins(0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        expect_cyc("waw_f4", 1, 0, 32'h54, 3, 1);
        nxt(); id_ins(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        expect_cyc("mc_x0_issue", 0, 0, 32'h54, 3, 1);
        nxt(); id_ins(0, 0, 0, 0, 0, 8, 1, 1, 1, 0); flush = 1;
        expect_cyc("mc_flushed", 0, 0, 32'h54, 3, 1);
        nxt();
        expect_cyc("untracked", 0, 0, 32'h54, 3, 1);

        // Asynchronous reset mid-stream
        nxt(); rst_n = 0; id_ins(4, 0, 0, 3'b100, 3'b100, 5, 1, 1, 0, 0);
        expect_cyc("mid_reset", 0, 0, 0, 0, 0);
        nxt(); rst_n = 1; wb(4, 1);
        expect_cyc("post_reset_wb", 0, 0, 0, 0, 0);
        nxt();
        expect_cyc("post_reset_err", 0, 0, 0, 0, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
